// File: rtl/accel_pkg.sv
// Shared encodings for the accelerator job scheduler: op codes and scheduler state.
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_STORE   = 2'b10;
  localparam logic [1:0] OP_COMPUTE = 2'b11;

  localparam int unsigned JOBS_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible unit at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o,
  output logic          any_o
);

  always_comb begin : sel
    logic [PW-1:0] j;
    logic          found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = PW'((32'(ptr_i) + i) % N);
      if (!found && eligible_i[j]) begin
        found       = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = j;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/multi_unit_scheduler.sv
// Dispatches jobs round-robin onto NUM_UNITS execution units, tracking completion
// and a per-unit watchdog that parks a hung unit behind a sticky error flag.
module multi_unit_scheduler
  import accel_pkg::*;
#(
  parameter int unsigned NUM_UNITS   = 4,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [1:0]                    job_op,
  input  logic [ADDR_W-1:0]             job_addr,
  output logic [NUM_UNITS-1:0]          unit_start,
  output logic [2*NUM_UNITS-1:0]        unit_op,
  output logic [ADDR_W*NUM_UNITS-1:0]   unit_addr,
  input  logic [NUM_UNITS-1:0]          unit_done,
  output logic [NUM_UNITS-1:0]          busy_mask,
  output logic [NUM_UNITS-1:0]          timeout_err,
  input  logic [NUM_UNITS-1:0]          clear_err,
  output logic [1:0]                    state,
  output logic [JOBS_W-1:0]             jobs_done
);

  localparam int unsigned PW      = $clog2(NUM_UNITS);
  localparam logic [15:0] WD_LOAD = 16'(TIMEOUT_CYC);

  sched_state_e                  state_q, state_d;
  logic [NUM_UNITS-1:0]          busy_q, busy_d;
  logic [NUM_UNITS-1:0]          err_q, err_d;
  logic [NUM_UNITS-1:0]          start_q, start_d;
  logic [2*NUM_UNITS-1:0]        op_q, op_d;
  logic [ADDR_W*NUM_UNITS-1:0]   addr_q, addr_d;
  logic [JOBS_W-1:0]             jobs_q, jobs_d;
  logic [PW-1:0]                 rr_q, rr_d;
  logic [15:0]                   wd_q [NUM_UNITS];
  logic [15:0]                   wd_d [NUM_UNITS];

  logic [NUM_UNITS-1:0]          eligible, grant, done_ok, expire;
  logic [PW-1:0]                 grant_idx;
  logic                          any_elig, accept;
  logic [4:0]                    done_cnt;
  logic [JOBS_W:0]               jobs_sum;

  assign eligible  = ~busy_q & ~err_q;
  assign job_ready = (state_q == RUN) && any_elig;
  assign accept    = job_valid && job_ready;

  rr_arbiter #(
    .N  (NUM_UNITS),
    .PW (PW)
  ) u_arb (
    .eligible_i  (eligible),
    .ptr_i       (rr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (any_elig)
  );

  always_comb begin
    done_ok  = unit_done & busy_q;
    expire   = '0;
    done_cnt = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      expire[i] = busy_q[i] && !unit_done[i] && (wd_q[i] == '0);
      done_cnt  = done_cnt + 5'(done_ok[i]);
    end

    start_d = accept ? grant : '0;
    busy_d  = (busy_q & ~done_ok & ~expire) | start_d;
    err_d   = (err_q & ~clear_err) | expire;

    op_d   = op_q;
    addr_d = addr_q;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (start_d[i]) begin
        op_d[2*i +: 2]           = job_op;
        addr_d[ADDR_W*i +: ADDR_W] = job_addr;
      end
      // A unit still busy next cycle without a fresh start always has wd_q > 0.
      if (start_d[i])     wd_d[i] = WD_LOAD;
      else if (busy_d[i]) wd_d[i] = wd_q[i] - 16'd1;
      else                wd_d[i] = '0;
    end

    jobs_sum = {1'b0, jobs_q} + (JOBS_W+1)'(done_cnt);
    jobs_d   = jobs_sum[JOBS_W] ? '1 : jobs_sum[JOBS_W-1:0];

    rr_d = rr_q;
    if (accept) begin
      rr_d = (32'(grant_idx) == NUM_UNITS - 1) ? '0 : grant_idx + PW'(1);
    end

    // Drain exits on the next-cycle busy set so IDLE follows the last done directly.
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)              state_d = RUN;
        else if (busy_d == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= '0;
      err_q   <= '0;
      start_q <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      jobs_q  <= '0;
      rr_q    <= '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) wd_q[i] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      start_q <= start_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      jobs_q  <= jobs_d;
      rr_q    <= rr_d;
      for (int unsigned i = 0; i < NUM_UNITS; i++) wd_q[i] <= wd_d[i];
    end
  end

  assign unit_start  = start_q;
  assign unit_op     = op_q;
  assign unit_addr   = addr_q;
  assign busy_mask   = busy_q;
  assign timeout_err = err_q;
  assign state       = state_q;
  assign jobs_done   = jobs_q;

endmodule

// File: tb/tb_multi_unit_scheduler.sv
// Scoreboarded bench for multi_unit_scheduler: dispatch, round-robin, watchdog, drain, reset.
module tb_multi_unit_scheduler;
  import accel_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        job_valid;
  logic        job_ready;
  logic [1:0]  job_op;
  logic [3:0]  job_addr;
  logic [3:0]  unit_start;
  logic [7:0]  unit_op;
  logic [15:0] unit_addr;
  logic [3:0]  unit_done;
  logic [3:0]  busy_mask;
  logic [3:0]  timeout_err;
  logic [3:0]  clear_err;
  logic [1:0]  state;
  logic [15:0] jobs_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  start;
    logic [1:0]  op;
    logic [3:0]  addr;
    int unsigned idx;
  } exp_t;
  exp_t sb[$];

  multi_unit_scheduler #(
    .NUM_UNITS   (4),
    .ADDR_W      (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_op      (job_op),
    .job_addr    (job_addr),
    .unit_start  (unit_start),
    .unit_op     (unit_op),
    .unit_addr   (unit_addr),
    .unit_done   (unit_done),
    .busy_mask   (busy_mask),
    .timeout_err (timeout_err),
    .clear_err   (clear_err),
    .state       (state),
    .jobs_done   (jobs_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    unit_done = '0;
    clear_err = '0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic offer(input logic [1:0] op, input logic [3:0] addr, input int unsigned unit);
    exp_t e;
    e.start       = '0;
    e.start[unit] = 1'b1;
    e.op          = op;
    e.addr        = addr;
    e.idx         = unit;
    job_valid = 1'b1;
    job_op    = op;
    job_addr  = addr;
    sb.push_back(e);
  endtask

  // Monitor: every start pulse must match the oldest expected dispatch.
  initial begin
    forever begin
      @(negedge clk);
      if (unit_start !== 4'b0000) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_unexpected: got %b expected none", unit_start);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("start_onehot", 32'(unit_start), 32'(e.start));
          chk("start_op", 32'(unit_op[2*e.idx +: 2]), 32'(e.op));
          chk("start_addr", 32'(unit_addr[4*e.idx +: 4]), 32'(e.addr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; job_valid = 1'b0; job_op = '0; job_addr = '0;
    unit_done = '0; clear_err = '0;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_busy", 32'(busy_mask), 32'h0);
    chk("rst_ready", 32'(job_ready), 32'h0);
    chk("rst_jobs", 32'(jobs_done), 32'h0);
    chk("rst_start", 32'(unit_start), 32'h0);

    next(); rst_n = 1'b1; enable = 1'b1;                       // c0
    // Dispatch: four back-to-back jobs land on units 0..3.
    next(); offer(OP_LOAD, 4'd1, 0); mid();                    // c1
    chk("run_state", 32'(state), 32'(RUN));
    chk("ready_c1", 32'(job_ready), 32'h1);
    next(); offer(OP_STORE, 4'd2, 1);                          // c2
    next(); offer(OP_COMPUTE, 4'd3, 2);                        // c3
    next(); offer(OP_NOP, 4'd4, 3);                            // c4
    next(); job_valid = 1'b1; job_addr = 4'd5; mid();          // c5
    chk("ready_full", 32'(job_ready), 32'h0);
    chk("busy_full", 32'(busy_mask), 32'hF);

    // Round-robin: free units 1 then 2, pointer sits at 0.
    next(); unit_done = 4'b0010;                               // c6
    next(); unit_done = 4'b0100; mid();                        // c7
    chk("busy_c7", 32'(busy_mask), 32'hD);
    next(); offer(OP_LOAD, 4'hA, 1); mid();                    // c8
    chk("busy_c8", 32'(busy_mask), 32'h9);
    chk("jobs_c8", 32'(jobs_done), 32'd2);
    next(); offer(OP_STORE, 4'hB, 2); mid();                   // c9
    chk("busy_c9", 32'(busy_mask), 32'hB);

    // Done on unit 0 exactly in its watchdog-zero cycle.
    next(); unit_done = 4'b0001; mid();                        // c10
    chk("busy_c10", 32'(busy_mask), 32'hF);
    next(); unit_done = 4'b0110; mid();                        // c11
    chk("tie_err", 32'(timeout_err), 32'h0);
    chk("tie_jobs", 32'(jobs_done), 32'd3);
    chk("busy_c11", 32'(busy_mask), 32'hE);
    next(); mid();                                             // c12
    chk("jobs_c12", 32'(jobs_done), 32'd5);

    // Unit 3 (busy since c5) expires: flag visible 9 cycles later at c14.
    next(); mid();                                             // c13
    chk("wd_pre_busy", 32'(busy_mask), 32'h8);
    chk("wd_pre_err", 32'(timeout_err), 32'h0);
    next(); offer(OP_COMPUTE, 4'h5, 0); mid();                 // c14: rr=3, unit 3 skipped
    chk("wd_err", 32'(timeout_err), 32'h8);
    chk("wd_busy", 32'(busy_mask), 32'h0);
    chk("wd_jobs", 32'(jobs_done), 32'd5);
    chk("ready_c14", 32'(job_ready), 32'h1);
    next(); clear_err = 4'b1000; mid();                        // c15
    chk("err_held", 32'(timeout_err), 32'h8);
    next(); offer(OP_LOAD, 4'h6, 1); mid();                    // c16
    chk("err_cleared", 32'(timeout_err), 32'h0);
    next(); offer(OP_STORE, 4'h7, 2);                          // c17
    next(); offer(OP_COMPUTE, 4'h8, 3);                        // c18
    next(); unit_done = 4'b0011; mid();                        // c19
    chk("busy_c19", 32'(busy_mask), 32'hF);

    // Drain with units 2 and 3 busy.
    next(); enable = 1'b0; mid();                              // c20
    chk("state_c20", 32'(state), 32'(RUN));
    chk("jobs_c20", 32'(jobs_done), 32'd7);
    chk("busy_c20", 32'(busy_mask), 32'hC);
    next(); job_valid = 1'b1; job_addr = 4'h9; unit_done = 4'b0100; mid(); // c21
    chk("drain_state", 32'(state), 32'(DRAIN));
    chk("drain_ready", 32'(job_ready), 32'h0);
    next(); unit_done = 4'b1000; mid();                        // c22
    chk("drain_hold", 32'(state), 32'(DRAIN));
    next(); enable = 1'b1; mid();                              // c23
    chk("drain_idle", 32'(state), 32'(IDLE));
    chk("jobs_c23", 32'(jobs_done), 32'd9);

    // Reset with three units busy.
    next(); offer(OP_LOAD, 4'hC, 0); mid();                    // c24
    chk("rerun_state", 32'(state), 32'(RUN));
    next(); offer(OP_STORE, 4'hD, 1);                          // c25
    next(); offer(OP_COMPUTE, 4'hE, 2);                        // c26
    next(); mid();                                             // c27
    chk("busy_c27", 32'(busy_mask), 32'h7);
    next(); job_valid = 1'b1; rst_n = 1'b0; #1;                // c28
    chk("mrst_state", 32'(state), 32'(IDLE));
    chk("mrst_busy", 32'(busy_mask), 32'h0);
    chk("mrst_op", 32'(unit_op), 32'h0);
    chk("mrst_addr", 32'(unit_addr), 32'h0);
    chk("mrst_jobs", 32'(jobs_done), 32'h0);
    chk("mrst_ready", 32'(job_ready), 32'h0);
    chk("mrst_start", 32'(unit_start), 32'h0);
    chk("mrst_err", 32'(timeout_err), 32'h0);
    next(); rst_n = 1'b1; mid();                               // c29
    chk("post_idle", 32'(state), 32'(IDLE));
    next(); mid();                                             // c30
    chk("post_run", 32'(state), 32'(RUN));
    next(); offer(OP_NOP, 4'hF, 0);                            // c31
    next(); unit_done = 4'b0001;                               // c32
    next(); mid();                                             // c33
    chk("post_jobs", 32'(jobs_done), 32'd1);
    chk("post_busy", 32'(busy_mask), 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_unit_scheduler.md
MULTI_UNIT_SCHEDULER -- requirements
Module: multi_unit_scheduler

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, number of execution units (2..16).
REQ-002 SHALL have parameter ADDR_W, default 4, job data-address width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, per-job watchdog limit in cycles (1..65535).
REQ-004 SHALL have port clk  input  1  system clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  run request; level, 1 = run, 0 = drain then stop.
REQ-006 SHALL have port job_valid  input  1  job offered; job_ready  output  1  job accepted this cycle if valid.
REQ-007 SHALL have port job_op  input  2  operation (NOP/LOAD/STORE/COMPUTE); job_addr  input  ADDR_W  data address.
REQ-008 SHALL have port unit_start  output  NUM_UNITS  one-cycle start pulse per unit.
REQ-009 SHALL have port unit_op  output  2*NUM_UNITS  per-unit op; unit_addr  output  ADDR_W*NUM_UNITS  per-unit address; both held until next start.
REQ-010 SHALL have port unit_done  input  NUM_UNITS  per-unit completion pulse.
REQ-011 SHALL have port busy_mask  output  NUM_UNITS  units holding a job; timeout_err  output  NUM_UNITS  sticky watchdog flags.
REQ-012 SHALL have port clear_err  input  NUM_UNITS  per-unit clear of timeout_err.
REQ-013 SHALL have port state  output  2  sched state; jobs_done  output  16  completed-job count.

Function
REQ-014 SHALL implement states IDLE(0), RUN(1), DRAIN(2): IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when busy_mask=0; DRAIN->RUN when enable=1.
REQ-015 SHALL treat a unit as eligible when busy=0 and timeout_err=0.
REQ-016 SHALL drive job_ready combinationally as (state==RUN) and (any unit eligible).
REQ-017 SHALL select, on acceptance (job_valid & job_ready), the first eligible unit searching upward from rr_ptr modulo NUM_UNITS.
REQ-018 SHALL, one cycle after acceptance, pulse unit_start[k], set busy[k], latch unit_op[k]/unit_addr[k], and set rr_ptr to (k+1) mod NUM_UNITS.
REQ-019 SHALL accept at most one job per cycle.
REQ-020 SHALL, on unit_done[i] with busy[i]=1, clear busy[i] next cycle and increment jobs_done, saturating at 16'hFFFF.
REQ-021 SHALL ignore unit_done[i] when busy[i]=0.
REQ-022 SHALL load unit i's watchdog with TIMEOUT_CYC in the cycle busy[i] rises, then decrement it once per busy cycle.
REQ-023 SHALL, when the watchdog is 0, busy[i]=1 and unit_done[i]=0, clear busy[i] and set timeout_err[i] next cycle, without incrementing jobs_done.
REQ-024 SHALL give unit_done precedence over an expiring watchdog in the same cycle, with no error set.
REQ-025 SHALL clear timeout_err[i] one cycle after clear_err[i]=1; a simultaneous new timeout on unit i SHALL win and keep the flag set.
REQ-026 SHALL continue completion and watchdog handling in DRAIN and IDLE, while accepting no new jobs.

Reset
REQ-027 SHALL, on rst_n=0 at any time (including mid-job), asynchronously force state=IDLE, busy_mask=0, timeout_err=0, unit_start=0, unit_op=0, unit_addr=0, jobs_done=0, rr_ptr=0, watchdogs=0.
REQ-028 SHALL drive job_ready=0 while in reset.

Structure
REQ-029 SHALL take op encoding constants (OP_NOP=00, OP_LOAD=01, OP_STORE=10, OP_COMPUTE=11) and enum sched_state_e from shared package accel_pkg.
REQ-030 SHALL implement selection in sub-module rr_arbiter (eligible mask plus pointer in, one-hot grant plus index out, purely combinational).

Verification
REQ-031 SHALL cover dispatch: NUM_UNITS=4, enable=1, 4 back-to-back jobs with addr 1..4 -> unit_start 0001,0010,0100,1000 on consecutive cycles; job_ready=0 on the 5th cycle.
REQ-032 SHALL cover round-robin: units 0..3 busy, done on unit 1, then unit 2, then one new job -> job goes to unit 1 (rr_ptr=0, first eligible from 0); a following job after unit 2 frees goes to unit 2.
REQ-033 SHALL cover watchdog: TIMEOUT_CYC=8, no done -> timeout_err[k]=1 and busy[k]=0 exactly 9 cycles after busy rises; jobs_done unchanged; unit k skipped until clear_err[k].
REQ-034 SHALL cover the done/timeout tie: done asserted in the watchdog-0 cycle -> no error and jobs_done+1.
REQ-035 SHALL cover drain: enable 1->0 with 2 units busy -> state=DRAIN, job_ready=0; state=IDLE the cycle after the last done.
REQ-036 SHALL cover reset mid-operation: rst_n low with 3 units busy -> all outputs zero immediately; after release, first job goes to unit 0.
